// File: rtl/datapath_unit.sv
// Operand capture datapath: synchronised enter -> one-cycle inputdata_ready pulse,
// 8-bit data register, binary-to-BCD and 4-digit active-low 7-segment display.
// Optional two's-complement display mode is enabled by defining DATAPATH_SIGNED_EN.
module datapath_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic [7:0] inputdata,
    input  logic       loaddata,
    output logic       inputdata_ready,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic       sync1_reg, sync2_reg, prev_reg;
    logic       fill1_reg, fill2_reg, armed_reg;
    logic       ready_reg;
    logic [7:0] data_reg;
    logic       rise;

    // The fill flags mark when sync2_reg holds a genuine post-reset sample; only a
    // genuine low arms the detector, so a press held through reset is ignored.
    assign rise = armed_reg & sync2_reg & ~prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            fill1_reg <= 1'b0;
            fill2_reg <= 1'b0;
            armed_reg <= 1'b0;
            ready_reg <= 1'b0;
            data_reg  <= 8'd0;
        end else begin
            sync1_reg <= enter;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            fill1_reg <= 1'b1;
            fill2_reg <= fill1_reg;
            if (fill2_reg && !sync2_reg) begin
                armed_reg <= 1'b1;
            end
            ready_reg <= rise;
            if (loaddata) begin
                data_reg <= inputdata;
            end
        end
    end

    assign inputdata_ready = ready_reg;

    logic       negative;
    logic [7:0] magnitude;

`ifdef DATAPATH_SIGNED_EN
    assign negative = data_reg[7];
`else
    assign negative = 1'b0;
`endif

    assign magnitude = negative ? (8'd0 - data_reg) : data_reg;

    // Shift-add-3: adjust each BCD digit before shifting in the next magnitude bit.
    logic [11:0] bcd;

    always_comb begin
        bcd = 12'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5)   bcd[3:0]   = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5)   bcd[7:4]   = bcd[7:4] + 4'd3;
            if (bcd[11:8] >= 4'd5)  bcd[11:8]  = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], magnitude[i]};
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [3:0] digit [3];
    logic [6:0] seg   [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign digit[gi] = bcd[gi*4 +: 4];
            assign seg[gi]   = seg7(digit[gi]);
        end
    endgenerate

    assign disp0 = seg[0];
    assign disp1 = (digit[2] == 4'd0 && digit[1] == 4'd0) ? SEG_BLANK : seg[1];
    assign disp2 = (digit[2] == 4'd0) ? SEG_BLANK : seg[2];
    assign disp3 = negative ? SEG_MINUS : SEG_BLANK;

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed and $urandom loads compared
// against an arithmetic (div/mod) display model; enter pulse timing and resets.
module tb_datapath_unit;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter;
    logic [7:0] inputdata;
    logic       loaddata;
    logic       inputdata_ready;
    logic [6:0] disp3, disp2, disp1, disp0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] shadow;

    always #5 clk = ~clk;

    datapath_unit dut (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata), .inputdata_ready(inputdata_ready),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
    );

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [27:0] model(input logic [7:0] v);
        int mag, h, t, u;
        bit neg;
        neg = 1'b0;
        mag = int'(v);
`ifdef DATAPATH_SIGNED_EN
        if (v[7]) begin
            neg = 1'b1;
            mag = 256 - int'(v);
        end
`endif
        h = mag / 100;
        t = (mag / 10) % 10;
        u = mag % 10;
        return {neg ? MINUS : BLANK,
                (h == 0) ? BLANK : code(h),
                (h == 0 && t == 0) ? BLANK : code(t),
                code(u)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] shown();
        return {4'd0, disp3, disp2, disp1, disp0};
    endfunction

    task automatic load(input logic [7:0] v);
        inputdata = v;
        loaddata  = 1'b1;
        step();
        loaddata  = 1'b0;
        shadow    = v;
        $display("load value=%0d display=%h", v, shown());
        check("load_display", shown(), {4'd0, model(v)});
    endtask

    task automatic press(input string tag);
        enter = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check(tag, {31'd0, inputdata_ready}, {31'd0, (k == 3)});
        end
        enter = 1'b0;
        repeat (4) step();
        $display("press %s done", tag);
    endtask

    initial begin
        reset = 1'b1; enter = 1'b0; loaddata = 1'b0; inputdata = 8'd0; shadow = 8'd0;
        repeat (2) step();
        check("reset_display", shown(), {4'd0, BLANK, BLANK, BLANK, 7'b1000000});
        check("reset_ready", {31'd0, inputdata_ready}, 32'd0);
        reset = 1'b0;
        repeat (5) step();
        check("post_reset_display", shown(), {4'd0, BLANK, BLANK, BLANK, 7'b1000000});

        press("press_pulse");

        load(8'd123);
        check("d123", shown(), {4'd0, BLANK, 7'b1111001, 7'b0100100, 7'b0110000});
        load(8'd7);
        check("d7", shown(), {4'd0, BLANK, BLANK, BLANK, 7'b1111000});
        load(8'd40);
        check("d40", shown(), {4'd0, BLANK, BLANK, 7'b0011001, 7'b1000000});
        load(8'hFF);
`ifdef DATAPATH_SIGNED_EN
        check("dFF", shown(), {4'd0, MINUS, BLANK, BLANK, 7'b1111001});
`else
        check("dFF", shown(), {4'd0, BLANK, 7'b0100100, 7'b0010010, 7'b0010010});
`endif
        load(8'h80);
`ifdef DATAPATH_SIGNED_EN
        check("d80", shown(), {4'd0, MINUS, 7'b1111001, 7'b0100100, 7'b0000000});
`else
        check("d80", shown(), {4'd0, BLANK, 7'b1111001, 7'b0100100, 7'b0000000});
`endif

        // Capture while the ready pulse is high: both must happen.
        enter = 1'b1;
        repeat (3) step();
        check("ready_with_load", {31'd0, inputdata_ready}, 32'd1);
        inputdata = 8'd55;
        loaddata  = 1'b1;
        step();
        loaddata  = 1'b0;
        shadow    = 8'd55;
        check("load_during_ready", shown(), {4'd0, model(8'd55)});
        check("ready_single", {31'd0, inputdata_ready}, 32'd0);
        enter = 1'b0;
        repeat (4) step();

        for (int n = 0; n < 20; n++) begin
            load(8'($urandom_range(0, 255)));
        end

        for (int n = 0; n < 20; n++) begin
            inputdata = 8'($urandom);
            step();
            check("hold", shown(), {4'd0, model(shadow)});
        end

        // Asynchronous reset mid-press, between clock edges.
        load(8'd123);
        enter = 1'b1;
        repeat (2) step();
        #3 reset = 1'b1;
        #1;
        check("async_reset_display", shown(), {4'd0, BLANK, BLANK, BLANK, 7'b1000000});
        check("async_reset_ready", {31'd0, inputdata_ready}, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("held_through_reset", {31'd0, inputdata_ready}, 32'd0);
        end
        enter = 1'b0;
        repeat (4) step();
        press("fresh_press");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
